msg_data_buffer: RTL and testbench

- Downstream consumer of one message channel of the two-ID message router (ClearMsgN / WriteMsgN / MsgNComplete / DataByte); one instance per message ID.
- Captures a message's data bytes into an on-chip byte RAM and freezes the finished message for the controller.
- Controller reads stored bytes by address, then releases the buffer for the next message.

---
 rtl/msg_buf_pkg.sv | 12 +
 rtl/msg_byte_ram.sv | 32 +++
 rtl/msg_data_buffer.sv | 149 ++++++++++++++
 tb/tb_msg_data_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_buf_pkg.sv
// Shared constants and state encoding for the message data buffer.
package msg_buf_pkg;

    localparam int unsigned DEFAULT_DEPTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/msg_byte_ram.sv
// DEPTH x 8 simple dual-port RAM: one write port, one registered read-first read port.
module msg_byte_ram #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    // Array itself is never reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/msg_data_buffer.sv
// One message channel's byte buffer: fills from the router, holds for the controller.
// Optional Checksum output enabled by defining MSG_BUF_CHECKSUM_EN.
module msg_data_buffer
    import msg_buf_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              ClearMsg,
    input  logic              WriteMsg,
    input  logic [7:0]        DataByte,
    input  logic              MsgComplete,
    input  logic              Release,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [7:0]        RdData,
    output logic              MsgReady,
    output logic [ADDR_W:0]   Length,
    output logic              Overflow,
    output logic              Dropped
`ifdef MSG_BUF_CHECKSUM_EN
    ,
    output logic [7:0]        Checksum
`endif
);

    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic              drop_q, drop_d;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ptr_clr;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ovf_d     = ovf_q;
        drop_d    = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = ptr_q[ADDR_W-1:0];
        ptr_clr   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ClearMsg) begin
                    state_d = ST_FILL;
                    ptr_clr = 1'b1;
                end
            end
            ST_FILL: begin
                if (ClearMsg) begin
                    // Restart; a coincident byte lands at address 0.
                    ptr_clr = 1'b1;
                    if (WriteMsg) begin
                        ram_we    = 1'b1;
                        ram_waddr = '0;
                    end
                end else begin
                    if (WriteMsg) begin
                        if (ptr_q < PTR_FULL) begin
                            ram_we = 1'b1;
                            ptr_d  = ptr_q + PTR_ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (MsgComplete) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (Release) begin
                    state_d = ST_IDLE;
                    if (ClearMsg) begin
                        state_d = ST_FILL;
                        ptr_clr = 1'b1;
                    end
                end else if (ClearMsg) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ptr_clr) begin
            ovf_d = 1'b0;
            ptr_d = ram_we ? PTR_ONE : '0;
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

`ifdef MSG_BUF_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = ptr_clr ? 8'h00 : csum_q;
        if (ram_we) begin
            csum_d = csum_d + DataByte;
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign Checksum = csum_q;
`endif

    msg_byte_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk    (Clock),
        .rst    (Clear),
        .we     (ram_we),
        .wr_addr(ram_waddr),
        .wr_data(DataByte),
        .rd_addr(RdAddr),
        .rd_data(RdData)
    );

    assign MsgReady = (state_q == ST_HOLD);
    assign Length   = ptr_q;
    assign Overflow = ovf_q;
    assign Dropped  = drop_q;

endmodule

// File: tb/tb_msg_data_buffer.sv
// Scenario bench for msg_data_buffer (DEPTH = 4); read results checked through a scoreboard queue.
module tb_msg_data_buffer;

    localparam int unsigned DEPTH = 4;

    logic       Clock;
    logic       Clear;
    logic       ClearMsg;
    logic       WriteMsg;
    logic [7:0] DataByte;
    logic       MsgComplete;
    logic       Release;
    logic [1:0] RdAddr;
    logic [7:0] RdData;
    logic       MsgReady;
    logic [2:0] Length;
    logic       Overflow;
    logic       Dropped;
`ifdef MSG_BUF_CHECKSUM_EN
    logic [7:0] Checksum;
`endif

    logic [7:0] exp_q[$];
    int vec;
    int miss;

    msg_data_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .ClearMsg   (ClearMsg),
        .WriteMsg   (WriteMsg),
        .DataByte   (DataByte),
        .MsgComplete(MsgComplete),
        .Release    (Release),
        .RdAddr     (RdAddr),
        .RdData     (RdData),
        .MsgReady   (MsgReady),
        .Length     (Length),
        .Overflow   (Overflow),
        .Dropped    (Dropped)
`ifdef MSG_BUF_CHECKSUM_EN
        ,
        .Checksum   (Checksum)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Drive one cycle of router/controller pulses; return 1 time unit after the edge.
    task automatic cyc(input logic cm, input logic wm, input logic mc, input logic rel,
                       input logic [7:0] d);
        ClearMsg    = cm;
        WriteMsg    = wm;
        MsgComplete = mc;
        Release     = rel;
        DataByte    = d;
        @(posedge Clock);
        #1;
        ClearMsg    = 1'b0;
        WriteMsg    = 1'b0;
        MsgComplete = 1'b0;
        Release     = 1'b0;
        DataByte    = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        vec++;
        if (Length !== 3'd0) begin
            miss++;
            $display("FAIL reset_length got %0d want 0", Length);
        end
        vec++;
        if ({MsgReady, Overflow, Dropped} !== 3'b000) begin
            miss++;
            $display("FAIL reset_flags got %b want 000", {MsgReady, Overflow, Dropped});
        end
        got = RdData;
        vec++;
        if (got !== 8'h00) begin
            miss++;
            $display("FAIL reset_rddata got %h want 00", got);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [3];
        logic [7:0] e;
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        cyc(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, bytes[i]);
        vec++;
        if (MsgReady !== 1'b0) begin
            miss++;
            $display("FAIL basic_ready_early got %b want 0", MsgReady);
        end
        cyc(0, 0, 1, 0, 8'h00);
        vec++;
        if (MsgReady !== 1'b1 || Length !== 3'd3) begin
            miss++;
            $display("FAIL basic_done got ready=%b len=%0d want ready=1 len=3", MsgReady, Length);
        end
`ifdef MSG_BUF_CHECKSUM_EN
        vec++;
        if (Checksum !== 8'h66) begin
            miss++;
            $display("FAIL basic_checksum got %h want 66", Checksum);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            RdAddr = 2'(i);
            exp_q.push_back(bytes[i]);
            @(posedge Clock);
            #1;
            e = exp_q.pop_front();
            vec++;
            if (RdData !== e) begin
                miss++;
                $display("FAIL basic_read[%0d] got %h want %h", i, RdData, e);
            end
        end
        cyc(0, 0, 0, 1, 8'h00);
        vec++;
        if (MsgReady !== 1'b0) begin
            miss++;
            $display("FAIL basic_release got %b want 0", MsgReady);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        cyc(1, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 6; i++) cyc(0, 1, 0, 0, 8'(i));
        cyc(0, 0, 1, 0, 8'h00);
        vec++;
        if (Length !== 3'd4 || Overflow !== 1'b1 || MsgReady !== 1'b1) begin
            miss++;
            $display("FAIL ovf_state got len=%0d ovf=%b ready=%b want 4 1 1",
                     Length, Overflow, MsgReady);
        end
`ifdef MSG_BUF_CHECKSUM_EN
        vec++;
        if (Checksum !== 8'h0A) begin
            miss++;
            $display("FAIL ovf_checksum got %h want 0a", Checksum);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            RdAddr = 2'(i);
            exp_q.push_back(8'(i + 1));
            @(posedge Clock);
            #1;
            e = exp_q.pop_front();
            vec++;
            if (RdData !== e) begin
                miss++;
                $display("FAIL ovf_read[%0d] got %h want %h", i, RdData, e);
            end
        end
    endtask

    // Entered in HOLD with the overflow message (0x01..0x04) still held.
    task automatic test_dropped();
        logic [7:0] e;
        cyc(1, 1, 0, 0, 8'hAA);
        vec++;
        if (Dropped !== 1'b1) begin
            miss++;
            $display("FAIL drop_pulse got %b want 1", Dropped);
        end
        cyc(0, 0, 0, 0, 8'h00);
        vec++;
        if (Dropped !== 1'b0 || Length !== 3'd4 || MsgReady !== 1'b1) begin
            miss++;
            $display("FAIL drop_after got drop=%b len=%0d ready=%b want 0 4 1",
                     Dropped, Length, MsgReady);
        end
        RdAddr = 2'd0;
        exp_q.push_back(8'h01);
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        vec++;
        if (RdData !== e) begin
            miss++;
            $display("FAIL drop_ram0 got %h want %h", RdData, e);
        end
        cyc(0, 0, 0, 1, 8'h00);
        vec++;
        if (MsgReady !== 1'b0) begin
            miss++;
            $display("FAIL drop_release got %b want 0", MsgReady);
        end
    endtask

    task automatic test_release_clear();
        logic [7:0] e;
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h10);
        cyc(0, 1, 0, 0, 8'h20);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(1, 0, 0, 1, 8'h00);
        vec++;
        if (Dropped !== 1'b0 || MsgReady !== 1'b0 || Length !== 3'd0) begin
            miss++;
            $display("FAIL relclr_state got drop=%b ready=%b len=%0d want 0 0 0",
                     Dropped, MsgReady, Length);
        end
        cyc(0, 1, 0, 0, 8'h5A);
        cyc(0, 0, 1, 0, 8'h00);
        vec++;
        if (Length !== 3'd1 || MsgReady !== 1'b1 || Dropped !== 1'b0) begin
            miss++;
            $display("FAIL relclr_done got len=%0d ready=%b drop=%b want 1 1 0",
                     Length, MsgReady, Dropped);
        end
        RdAddr = 2'd0;
        exp_q.push_back(8'h5A);
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        vec++;
        if (RdData !== e) begin
            miss++;
            $display("FAIL relclr_ram0 got %h want %h", RdData, e);
        end
        cyc(0, 0, 0, 1, 8'h00);
    endtask

    task automatic test_write_complete();
        logic [7:0] e;
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h66);
        cyc(0, 1, 1, 0, 8'h77);
        vec++;
        if (Length !== 3'd2 || MsgReady !== 1'b1) begin
            miss++;
            $display("FAIL wrcmp_state got len=%0d ready=%b want 2 1", Length, MsgReady);
        end
        RdAddr = 2'd1;
        exp_q.push_back(8'h77);
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        vec++;
        if (RdData !== e) begin
            miss++;
            $display("FAIL wrcmp_ram1 got %h want %h", RdData, e);
        end
        cyc(0, 0, 0, 1, 8'h00);
    endtask

    task automatic test_async_clear();
        logic [7:0] e;
        RdAddr = 2'd0;
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'hC1);
        cyc(0, 1, 0, 0, 8'hC2);
        vec++;
        if (RdData !== 8'hC1 || Length !== 3'd2) begin
            miss++;
            $display("FAIL aclr_pre got rd=%h len=%0d want c1 2", RdData, Length);
        end
        #2 Clear = 1'b1;
        #1;
        vec++;
        if (Length !== 3'd0 || RdData !== 8'h00 || MsgReady !== 1'b0 || Overflow !== 1'b0) begin
            miss++;
            $display("FAIL aclr_now got len=%0d rd=%h ready=%b ovf=%b want 0 00 0 0",
                     Length, RdData, MsgReady, Overflow);
        end
        #2 Clear = 1'b0;
        @(posedge Clock);
        #1;
        cyc(0, 1, 0, 0, 8'h99);
        vec++;
        if (Length !== 3'd0) begin
            miss++;
            $display("FAIL aclr_idle_write got len=%0d want 0", Length);
        end
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'hE5);
        cyc(0, 0, 1, 0, 8'h00);
        vec++;
        if (Length !== 3'd1 || MsgReady !== 1'b1) begin
            miss++;
            $display("FAIL aclr_next got len=%0d ready=%b want 1 1", Length, MsgReady);
        end
        for (int i = 0; i < 2; i++) begin
            RdAddr = 2'(i);
            // Address 1 is beyond Length and still holds the lost message's byte.
            exp_q.push_back(i == 0 ? 8'hE5 : 8'hC2);
            @(posedge Clock);
            #1;
            e = exp_q.pop_front();
            vec++;
            if (RdData !== e) begin
                miss++;
                $display("FAIL aclr_read[%0d] got %h want %h", i, RdData, e);
            end
        end
        cyc(0, 0, 0, 1, 8'h00);
    endtask

    initial begin
        vec         = 0;
        miss        = 0;
        Clear       = 1'b1;
        ClearMsg    = 1'b0;
        WriteMsg    = 1'b0;
        DataByte    = 8'h00;
        MsgComplete = 1'b0;
        Release     = 1'b0;
        RdAddr      = 2'd0;
        #12;
        test_reset();
        Clear = 1'b0;
        @(posedge Clock);
        #1;
        test_basic();
        test_overflow();
        test_dropped();
        test_release_clear();
        test_write_complete();
        test_async_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
